// File: rtl/mcast_replicator.sv
// mcast_replicator: buffers mask-tagged flits and replicates each head flit to every selected output port,
// retiring it once all selected ports have handshaken, possibly in different cycles.
module mcast_replicator #(
    parameter int FLIT_W     = 64,
    parameter int NPORTS     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W-1:0]        flit_in,
    input  logic [NPORTS-1:0]        mask_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    output logic [FLIT_W*NPORTS-1:0] flit_out_flat,
    output logic [NPORTS-1:0]        valid_out_flat,
    input  logic [NPORTS-1:0]        ready_in_flat,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         pkt_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t              r_state, w_state_nxt;
    logic [FLIT_W-1:0]   r_mem_flit [FIFO_DEPTH];
    logic [NPORTS-1:0]   r_mem_mask [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]       r_count, w_count_nxt;
    logic                r_ready;
    logic [FLIT_W-1:0]   r_head;
    logic [NPORTS-1:0]   r_pend, w_pend_nxt;
    logic [CNT_W-1:0]    r_drop_cnt, r_pkt_cnt;
    logic                w_acc, w_push, w_drop, w_empty, w_retire, w_pop;

    assign w_acc       = valid_in & r_ready;
    assign w_push      = w_acc & |mask_in;
    assign w_drop      = w_acc & ~|mask_in;
    assign w_empty     = r_count == '0;
    assign w_pend_nxt  = r_pend & ~(valid_out_flat & ready_in_flat);
    assign w_retire    = (r_state == SEND) && (w_pend_nxt == '0);
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_retire);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign ready_out   = r_ready;
    assign drop_cnt    = r_drop_cnt;
    assign pkt_cnt     = r_pkt_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // A retiring flit is immediately replaced by the next entry, so SEND can persist without a gap.
    always_comb begin
        w_state_nxt = ((r_state == IDLE) || w_retire) ? (w_empty ? IDLE : SEND) : r_state;
    end

    always_comb begin
        valid_out_flat = (r_state == SEND) ? r_pend : '0;
        flit_out_flat  = (r_state == SEND) ? {NPORTS{r_head}} : '0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_flit[r_wr_ptr] <= flit_in;
            r_mem_mask[r_wr_ptr] <= mask_in;
        end
    end

    // ready_out is a registered view of the next count; a pop cannot free a slot for the same-cycle push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_ready <= w_count_nxt < CW'(FIFO_DEPTH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_pend <= '0;
        end else if (w_pop) begin
            r_head <= r_mem_flit[r_rd_ptr];
            r_pend <= r_mem_mask[r_rd_ptr];
        end else if (r_state == SEND) begin
            r_pend <= w_pend_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            if (w_drop && !(&r_drop_cnt))  r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            if (w_retire && !(&r_pkt_cnt)) r_pkt_cnt  <= r_pkt_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/mcast_replicator.md
Name: mcast_replicator

Overview:
- Multicast replication stage for the router output side, generalising router_cell's ENABLE_MCAST scaffold, where replication is not implemented.
- Accepts flits tagged with a destination port bitmask, buffers them in a small FIFO, and presents each head flit on every port selected by the mask.
- A flit is retired only after every selected port has completed its own valid/ready handshake; ports may accept in different cycles.
- Sits between the router crossbar/arbiter and the NPORTS output links.

Parameters:
- FLIT_W, 64, flit width in bits.
- NPORTS, 5, number of output ports (N/E/S/W/Local); legal range 1..16.
- FIFO_DEPTH, 4, input FIFO entries; power of two, >=2.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flit_in  in  FLIT_W  incoming flit.
- mask_in  in  NPORTS  destination bitmask; bit i selects port i.
- valid_in  in  1  flit_in/mask_in valid.
- ready_out  out  1  block can accept; a transfer occurs when valid_in & ready_out.
- flit_out_flat  out  FLIT_W*NPORTS  head flit replicated on each port slice; slice i = [i*FLIT_W +: FLIT_W].
- valid_out_flat  out  NPORTS  per-port valid.
- ready_in_flat  in  NPORTS  per-port downstream ready.
- drop_cnt  out  CNT_W  count of zero-mask flits discarded, saturating.
- pkt_cnt  out  CNT_W  count of fully retired flits, saturating.

Behaviour:
- Reset (async, while rst=1): FIFO empty, head invalid, pending=0, both counters 0, ready_out=0, valid_out_flat=0, flit_out_flat=0. Outputs return to normal from the first clk edge after rst deasserts. Reset mid-replication discards the head and all buffered flits with no partial delivery tracking.
- ready_out = !rst && (fifo_count < FIFO_DEPTH). It is registered from the count and has no same-cycle bypass of pops. When the FIFO is full and a pop happens in the same cycle, the push is still refused.
- Accept, mask != 0: {flit_in, mask_in} is written to the FIFO.
- Accept, mask == 0: the flit is consumed but not written; drop_cnt increments and holds at all-ones.
- Head register with two states:
  - IDLE: head invalid. If the FIFO is non-empty, pop into the head, set pending = mask, and go to SEND.
  - SEND: valid_out_flat[i] = pending[i]. On each edge, pending clears every bit i where valid_out_flat[i] & ready_in_flat[i]. When the next pending value is 0, the flit is retired and pkt_cnt increments (saturating). On that same edge, if the FIFO is non-empty, the next entry loads directly and the state stays SEND; otherwise it returns to IDLE.
- flit_out_flat: each slice equals the head flit while in SEND, and 0 in IDLE.
- Once a port accepts, its valid drops for the rest of that flit; a port never sees the same flit twice.
- Latency: a flit accepted at edge t appears on valid_out_flat after edge t+1.
- Throughput: 1 flit/cycle when all selected ports are ready.
- Simultaneous push and pop: fifo_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- ready_in_flat bits for non-pending ports are ignored.
- Valid stability: while pending[i]=1 and ready_in_flat[i]=0, valid_out_flat[i] and its flit slice hold stable.

Test Plan:
- Unicast fallback: NPORTS=5; flit 0x00000000DEADBEEF with mask 5'b10000, all ready. Expect valid_out_flat=5'b10000 exactly one cycle, 2 edges after accept, slice 4 = 0xDEADBEEF, pkt_cnt=1.
- Broadcast with staggered ready: mask 5'b11111; ready_in raised one port per cycle from port 0 to port 4. Expect each valid bit to drop the cycle after its port's ready; the flit retires after the 5th accept; pkt_cnt=1; ready_out stays 1.
- Back-to-back: 4 flits, masks 5'b00011, 5'b00100, 5'b11000, 5'b00001, all ready. Expect 4 consecutive SEND cycles with no IDLE gap, and pkt_cnt=4.
- Full/backpressure: ready_in_flat=0; push 5 flits. Expect ready_out=0 after the FIFO fills (head + 4 entries) and the 6th valid_in not accepted. Release ready and expect in-order delivery.
- Zero mask: 3 flits with mask 0 interleaved with 1 flit with mask 5'b00001. Expect drop_cnt=3 and only that flit delivered. Separately, force drop_cnt to all-ones and expect it to hold at 0xFFFF.
- Reset mid-operation: assert rst asynchronously (not on an edge) during SEND with 2 flits queued. Expect valid_out_flat=0 and ready_out=0 immediately, both counters 0, and no stale flit emitted after release.
